// File: rtl/ber_sync_pkg.sv
// Shared types and width helpers for the BER synchroniser: FSM state encoding,
// a constant clog2 and the widths used by the default build.
package ber_sync_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_MAX_DELAY = 16;
  localparam int DEF_WINDOW    = 256;
  localparam int DLY_W         = clog2(DEF_MAX_DELAY);
  localparam int WIN_W         = clog2(DEF_WINDOW + 1);

endpackage

// File: rtl/ber_sync_delay_line.sv
// Enable-gated history of the reference bit; tap k is the reference k symbols ago,
// tap 0 being the bit currently on the input.
module bit_delay_line #(
  parameter int MAX_DELAY = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_bit,
  output logic [MAX_DELAY-1:0] o_taps
);

  logic [MAX_DELAY-2:0] r_hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
    end else if (i_en) begin
      r_hist <= (r_hist << 1) | (MAX_DELAY-1)'(i_bit);
    end
  end

  assign o_taps = {r_hist, i_bit};

endmodule

// File: rtl/ber_sync.sv
// BER checker with automatic delay search: finds the reference delay with the fewest
// errors, locks on it, keeps saturating bit/error counts and re-searches on loss of lock.
module ber_sync
  import ber_sync_pkg::*;
#(
  parameter int MAX_DELAY   = DEF_MAX_DELAY,
  parameter int WINDOW      = DEF_WINDOW,
  parameter int LOCK_THRESH = 8,
  parameter int CNT_W       = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        sx,
  input  logic                        dx,
  input  logic                        clear,
  output logic                        o_locked,
  output logic [clog2(MAX_DELAY)-1:0] o_delay,
  output logic [CNT_W-1:0]            o_bit_count,
  output logic [CNT_W-1:0]            o_err_count,
  output logic                        o_error_flag
);

  // Default build shares the package widths; other sizes derive their own.
  localparam int DW = (MAX_DELAY == DEF_MAX_DELAY) ? DLY_W : clog2(MAX_DELAY);
  localparam int WW = (WINDOW == DEF_WINDOW) ? WIN_W : clog2(WINDOW + 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
  localparam logic [DW-1:0] CAND_LAST = DW'(MAX_DELAY - 1);
  localparam logic [31:0]   THRESH    = 32'(LOCK_THRESH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  state_t               r_state, w_state_nxt;
  logic [DW-1:0]        r_cand, r_best_d, r_delay;
  logic [WW-1:0]        r_win_cnt, r_win_err, r_best_err;
  logic [CNT_W-1:0]     r_bit_cnt, r_err_cnt;
  logic                 r_err_flag;
  logic [MAX_DELAY-1:0] w_taps;
  logic [DW-1:0]        w_sel, w_min_d;
  logic [WW-1:0]        w_err_tot, w_min_err;
  logic                 w_mis, w_win_end, w_last_cand, w_better, w_lock_ok, w_over;
  logic                 w_go_lock, w_lose_lock;

  bit_delay_line #(.MAX_DELAY(MAX_DELAY)) u_hist (
    .clk    (clk),
    .rst    (rst),
    .i_en   (enable),
    .i_bit  (sx),
    .o_taps (w_taps)
  );

  assign w_sel       = (r_state == LOCKED) ? r_delay : r_cand;
  assign w_mis       = dx ^ w_taps[w_sel];
  assign w_win_end   = (r_win_cnt == WIN_LAST);
  assign w_err_tot   = r_win_err + WW'(w_mis);
  // Strict compare keeps the lower delay on ties.
  assign w_better    = (w_err_tot < r_best_err);
  assign w_min_err   = w_better ? w_err_tot : r_best_err;
  assign w_min_d     = w_better ? r_cand : r_best_d;
  assign w_last_cand = (r_cand == CAND_LAST);
  assign w_lock_ok   = (32'(w_min_err) <= THRESH);
  assign w_over      = (32'(w_err_tot) > THRESH);

  always_comb begin
    w_state_nxt = r_state;
    w_go_lock   = 1'b0;
    w_lose_lock = 1'b0;
    if (enable) begin
      case (r_state)
        SEARCH: begin
          if (w_win_end && w_last_cand && w_lock_ok) begin
            w_state_nxt = LOCKED;
            w_go_lock   = 1'b1;
          end
        end
        LOCKED: begin
          if (w_win_end && w_over) begin
            w_state_nxt = SEARCH;
            w_lose_lock = 1'b1;
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= SEARCH;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cand     <= '0;
      r_best_d   <= '0;
      r_best_err <= '1;
      r_delay    <= '0;
      r_win_cnt  <= '0;
      r_win_err  <= '0;
      r_err_flag <= 1'b0;
    end else if (enable) begin
      r_win_cnt <= w_win_end ? '0 : r_win_cnt + WW'(1);
      r_win_err <= w_win_end ? '0 : w_err_tot;
      if (r_state == SEARCH) begin
        if (w_win_end) begin
          if (w_last_cand) begin
            // Whether or not we lock, the next search starts from scratch.
            r_cand     <= '0;
            r_best_d   <= '0;
            r_best_err <= '1;
            if (w_go_lock) r_delay <= w_min_d;
          end else begin
            r_cand     <= r_cand + DW'(1);
            r_best_d   <= w_min_d;
            r_best_err <= w_min_err;
          end
        end
      end else begin
        r_err_flag <= w_lose_lock ? 1'b0 : w_mis;
      end
    end
  end

  // Clear wins over the stored count but not over the current symbol's increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
    end else if (enable && (r_state == LOCKED)) begin
      r_bit_cnt <= sat_inc(clear ? '0 : r_bit_cnt, 1'b1);
      r_err_cnt <= sat_inc(clear ? '0 : r_err_cnt, w_mis);
    end else if (clear) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
    end
  end

  assign o_locked     = (r_state == LOCKED);
  assign o_delay      = r_delay;
  assign o_bit_count  = r_bit_cnt;
  assign o_err_count  = r_err_cnt;
  assign o_error_flag = r_err_flag;

endmodule
